// File: rtl/hash64_arbiter_if.sv
// Bundle of request, hash-unit and response signals shared between
// the requester/hash-unit environment (master) and the arbiter (slave).
interface hash64_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]    req_valid;
    logic [64*N_REQ-1:0] req_key;
    logic [64*N_REQ-1:0] req_mask;
    logic [N_REQ-1:0]    req_ready;
    logic [63:0]         hash_key;
    logic [63:0]         hash_mask;
    logic [63:0]         hash_in;
    logic                resp_valid;
    logic                resp_ready;
    logic [ID_W-1:0]     resp_id;
    logic [63:0]         resp_key;
    logic [63:0]         resp_hash;
    logic                busy;

    // Environment side: requesters, the shared hash unit and the consumer.
    modport master (
        output req_valid, req_key, req_mask, hash_in, resp_ready,
        input  req_ready, hash_key, hash_mask, resp_valid, resp_id,
               resp_key, resp_hash, busy
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_key, req_mask, hash_in, resp_ready,
        output req_ready, hash_key, hash_mask, resp_valid, resp_id,
               resp_key, resp_hash, busy
    );
endinterface

// File: rtl/hash64_arbiter.sv
// Round-robin scheduler sharing one pipelined hash64 unit among N_REQ
// requesters. A tag shift register follows each key through the hash
// pipeline, and results land in a credit-protected FWFT response FIFO
// so a stalled consumer never loses a hash.
module hash64_arbiter #(
    parameter int N_REQ      = 4,
    parameter int ID_W       = 2,
    parameter int HASH_LAT   = 7,
    parameter int RESP_DEPTH = 8
) (
    input logic              clk,
    input logic              rst,
    hash64_arbiter_if.slave  bus
);
    localparam int CRED_W = $clog2(RESP_DEPTH + 1);
    localparam int PTR_W  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   grant_id;
    logic              grant_found;
    logic [CRED_W-1:0] credits;
    logic [CRED_W-1:0] fifo_count;
    logic              pop;
    logic              push;
    logic              issue;

    logic              tag_valid [HASH_LAT];
    logic [ID_W-1:0]   tag_id    [HASH_LAT];
    logic [63:0]       tag_key   [HASH_LAT];

    logic [ID_W-1:0]   mem_id    [RESP_DEPTH];
    logic [63:0]       mem_key   [RESP_DEPTH];
    logic [63:0]       mem_hash  [RESP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // A pop frees a credit in the same cycle, so a full arbiter can still
    // issue one request alongside it without ever overfilling the FIFO.
    assign pop   = (fifo_count != '0) && bus.resp_ready;
    assign push  = tag_valid[HASH_LAT-1];
    assign issue = !rst && grant_found &&
                   ((credits < CRED_W'(RESP_DEPTH)) || pop);

    // Search for the first valid requester starting at ptr, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!grant_found && bus.req_valid[(int'(ptr) + k) % N_REQ]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'((int'(ptr) + k) % N_REQ);
            end
        end
    end

    // Present the grant and drive the hash unit only on an actual issue.
    always_comb begin
        bus.req_ready = '0;
        bus.hash_key  = '0;
        bus.hash_mask = '0;
        if (issue) begin
            bus.req_ready[grant_id] = 1'b1;
            bus.hash_key  = bus.req_key[int'(grant_id)*64 +: 64];
            bus.hash_mask = bus.req_mask[int'(grant_id)*64 +: 64];
        end
    end

    // Rotate the priority pointer past each winner and track outstanding credits.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            credits <= '0;
        end else begin
            if (issue) begin
                ptr <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
            end
            if (issue && !pop) begin
                credits <= credits + CRED_W'(1);
            end else if (pop && !issue) begin
                credits <= credits - CRED_W'(1);
            end
        end
    end

    // Tag valid bits march alongside the hash pipeline; reset drops all of them.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < HASH_LAT; s++) begin
                tag_valid[s] <= 1'b0;
            end
        end else begin
            tag_valid[0] <= issue;
            for (int s = 1; s < HASH_LAT; s++) begin
                tag_valid[s] <= tag_valid[s-1];
            end
        end
    end

    // Tag payload (requester id and original key) shifts without reset.
    always_ff @(posedge clk) begin
        tag_id[0]  <= grant_id;
        tag_key[0] <= bus.hash_key;
        for (int s = 1; s < HASH_LAT; s++) begin
            tag_id[s]  <= tag_id[s-1];
            tag_key[s] <= tag_key[s-1];
        end
    end

    // FIFO storage captures the tag and the hash as they leave the pipeline.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_id[wr_ptr]   <= tag_id[HASH_LAT-1];
            mem_key[wr_ptr]  <= tag_key[HASH_LAT-1];
            mem_hash[wr_ptr] <= bus.hash_in;
        end
    end

    // FIFO pointers and occupancy; credits guarantee a push never finds it full.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(RESP_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(RESP_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CRED_W'(1);
            end else if (pop && !push) begin
                fifo_count <= fifo_count - CRED_W'(1);
            end
        end
    end

    assign bus.resp_valid = (fifo_count != '0);
    assign bus.resp_id    = mem_id[rd_ptr];
    assign bus.resp_key   = mem_key[rd_ptr];
    assign bus.resp_hash  = mem_hash[rd_ptr];
    assign bus.busy       = (credits != '0);
endmodule

// File: tb/tb_hash64_arbiter.sv
// Directed bench for hash64_arbiter: models the shared hash unit as a
// HASH_LAT-deep pipeline of the minimap2 hash64 and walks through single
// request, pointer hold/wrap, reset mid-flight, fairness and backpressure.
module tb_hash64_arbiter;
    localparam int N_REQ      = 4;
    localparam int ID_W       = 2;
    localparam int HASH_LAT   = 7;
    localparam int RESP_DEPTH = 8;

    localparam logic [63:0] K0       = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] K1       = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] K2       = 64'h0F0F_F0F0_1234_5678;
    localparam logic [63:0] K3       = 64'hA5A5_5A5A_C3C3_3C3C;
    localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] BP_MASK  = 64'h0000_FFFF_FFFF_FFFF;
    localparam logic [63:0] BP_BASE  = 64'hB0B0_0000_0000_0000;
    localparam logic [63:0] RST_BASE = 64'h0000_0000_DEAD_0000;

    logic        clk;
    logic        rst;
    int          checks;
    int          errors;
    logic [63:0] key_tab [4];
    logic [63:0] hpipe [HASH_LAT];
    logic [63:0] bp_expect [8];

    hash64_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

    hash64_arbiter #(
        .N_REQ(N_REQ), .ID_W(ID_W), .HASH_LAT(HASH_LAT), .RESP_DEPTH(RESP_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // minimap2 hash64 reference
    function automatic logic [63:0] hash64(input logic [63:0] key_in, input logic [63:0] mask);
        logic [63:0] k;
        k = (~key_in + (key_in << 21)) & mask;
        k = k ^ (k >> 24);
        k = ((k + (k << 3)) + (k << 8)) & mask;
        k = k ^ (k >> 14);
        k = ((k + (k << 2)) + (k << 4)) & mask;
        k = k ^ (k >> 28);
        k = (k + (k << 31)) & mask;
        return k;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared hash unit: fixed-latency pipeline of the reference hash.
    always @(posedge clk) begin
        hpipe[0] <= hash64(bus.hash_key, bus.hash_mask);
        for (int i = 1; i < HASH_LAT; i++) begin
            hpipe[i] <= hpipe[i-1];
        end
    end
    assign bus.hash_in = hpipe[HASH_LAT-1];

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        key_tab[0] = K0;
        key_tab[1] = K1;
        key_tab[2] = K2;
        key_tab[3] = K3;
        rst            = 1'b1;
        bus.req_valid  = '0;
        bus.req_key    = '0;
        bus.req_mask   = '0;
        bus.resp_ready = 1'b0;

        // ---- reset state, req_ready forced low while rst is high
        next_cycle();
        bus.req_valid = 4'hF;
        settle();
        check_output("rst_req_ready", 64'(bus.req_ready), 64'h0);
        check_output("rst_resp_valid", 64'(bus.resp_valid), 64'h0);
        check_output("rst_busy", 64'(bus.busy), 64'h0);
        check_output("rst_hash_key", bus.hash_key, 64'h0);
        check_output("rst_hash_mask", bus.hash_mask, 64'h0);
        next_cycle();
        rst            = 1'b0;
        bus.req_valid  = '0;
        bus.resp_ready = 1'b1;
        settle();
        check_output("idle_busy", 64'(bus.busy), 64'h0);

        // ---- single request from requester 2
        $display("[TB] single request");
        next_cycle();
        bus.req_valid = 4'b0100;
        bus.req_key   = {64'h0, 64'h1234, 64'h0, 64'h0};
        bus.req_mask  = '0;
        settle();
        check_output("single_req_ready", 64'(bus.req_ready), 64'h4);
        check_output("single_hash_key", bus.hash_key, 64'h1234);
        check_output("single_hash_mask", bus.hash_mask, 64'h0);
        next_cycle();
        bus.req_valid = '0;
        settle();
        check_output("single_busy", 64'(bus.busy), 64'h1);
        for (int c = 1; c < 8; c++) begin
            check_output("single_early_valid", 64'(bus.resp_valid), 64'h0);
            next_cycle();
            settle();
        end
        check_output("single_resp_valid", 64'(bus.resp_valid), 64'h1);
        check_output("single_resp_id", 64'(bus.resp_id), 64'h2);
        check_output("single_resp_key", bus.resp_key, 64'h1234);
        check_output("single_resp_hash", bus.resp_hash, 64'h0);
        next_cycle();
        settle();
        check_output("single_busy_clear", 64'(bus.busy), 64'h0);
        check_output("single_valid_clear", 64'(bus.resp_valid), 64'h0);

        // ---- pointer holds at 3 over idle cycles, then wraps to 0
        $display("[TB] pointer hold and wrap");
        repeat (3) next_cycle();
        bus.req_valid = 4'b1001;
        bus.req_key   = {K3, K2, K1, K0};
        bus.req_mask  = {ALL_ONES, ALL_ONES, ALL_ONES, ALL_ONES};
        settle();
        check_output("ptr_hold_grant", 64'(bus.req_ready), 64'h8);
        check_output("ptr_hold_key", bus.hash_key, K3);
        next_cycle();
        settle();
        check_output("ptr_wrap_grant", 64'(bus.req_ready), 64'h1);
        check_output("ptr_wrap_key", bus.hash_key, K0);
        next_cycle();
        bus.req_valid = '0;
        repeat (6) next_cycle();
        settle();
        check_output("ptr_resp0_id", 64'(bus.resp_id), 64'h3);
        check_output("ptr_resp0_hash", bus.resp_hash, hash64(K3, ALL_ONES));
        next_cycle();
        settle();
        check_output("ptr_resp1_id", 64'(bus.resp_id), 64'h0);
        check_output("ptr_resp1_hash", bus.resp_hash, hash64(K0, ALL_ONES));
        next_cycle();
        settle();
        check_output("ptr_busy_clear", 64'(bus.busy), 64'h0);

        // ---- reset while 5 operations are in flight
        $display("[TB] reset mid-operation");
        next_cycle();
        for (int c = 0; c < 5; c++) begin
            bus.req_valid = 4'b0001;
            bus.req_key   = {192'h0, RST_BASE + 64'(c)};
            settle();
            check_output("inflight_grant", 64'(bus.req_ready), 64'h1);
            next_cycle();
        end
        rst = 1'b1;
        settle();
        check_output("midrst_req_ready", 64'(bus.req_ready), 64'h0);
        check_output("midrst_hash_key", bus.hash_key, 64'h0);
        next_cycle();
        rst           = 1'b0;
        bus.req_valid = '0;
        settle();
        check_output("postrst_busy", 64'(bus.busy), 64'h0);
        check_output("postrst_resp_valid", 64'(bus.resp_valid), 64'h0);
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            settle();
            check_output("postrst_discard", 64'(bus.resp_valid), 64'h0);
        end

        // ---- fairness: all four valid, pointer restarts at 0 after reset
        $display("[TB] fairness");
        next_cycle();
        for (int c = 0; c < 8; c++) begin
            bus.req_valid = 4'hF;
            bus.req_key   = {K3, K2, K1, K0};
            bus.req_mask  = {ALL_ONES, ALL_ONES, ALL_ONES, ALL_ONES};
            settle();
            check_output("fair_grant", 64'(bus.req_ready), 64'(1 << (c % 4)));
            check_output("fair_hash_key", bus.hash_key, key_tab[c % 4]);
            next_cycle();
        end
        bus.req_valid = '0;
        settle();
        for (int c = 0; c < 8; c++) begin
            check_output("fair_resp_valid", 64'(bus.resp_valid), 64'h1);
            check_output("fair_resp_id", 64'(bus.resp_id), 64'(c % 4));
            check_output("fair_resp_key", bus.resp_key, key_tab[c % 4]);
            check_output("fair_resp_hash", bus.resp_hash, hash64(key_tab[c % 4], ALL_ONES));
            next_cycle();
            settle();
        end
        check_output("fair_busy_clear", 64'(bus.busy), 64'h0);
        check_output("fair_valid_clear", 64'(bus.resp_valid), 64'h0);

        // ---- backpressure: consumer stalled, requester 0 always valid
        $display("[TB] backpressure");
        next_cycle();
        bus.resp_ready = 1'b0;
        bus.req_mask   = {192'h0, BP_MASK};
        for (int c = 0; c < 8; c++) begin
            bus.req_valid = 4'b0001;
            bus.req_key   = {192'h0, BP_BASE + 64'(c)};
            settle();
            check_output("bp_accept", 64'(bus.req_ready), 64'h1);
            next_cycle();
        end
        for (int c = 8; c < 20; c++) begin
            settle();
            check_output("bp_stall", 64'(bus.req_ready), 64'h0);
            next_cycle();
        end
        bus.req_key    = {192'h0, BP_BASE + 64'd20};
        bus.resp_ready = 1'b1;
        settle();
        check_output("bp_pop_valid", 64'(bus.resp_valid), 64'h1);
        check_output("bp_pop_key", bus.resp_key, BP_BASE);
        check_output("bp_pop_hash", bus.resp_hash, hash64(BP_BASE, BP_MASK));
        check_output("bp_pop_issue", 64'(bus.req_ready), 64'h1);
        next_cycle();
        bus.resp_ready = 1'b0;
        settle();
        check_output("bp_full_again", 64'(bus.req_ready), 64'h0);
        check_output("bp_busy", 64'(bus.busy), 64'h1);
        repeat (7) next_cycle();
        bus.req_valid  = '0;
        bus.resp_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            bp_expect[c] = BP_BASE + 64'(c + 1);
        end
        bp_expect[7] = BP_BASE + 64'd20;
        settle();
        for (int c = 0; c < 8; c++) begin
            check_output("bp_drain_valid", 64'(bus.resp_valid), 64'h1);
            check_output("bp_drain_id", 64'(bus.resp_id), 64'h0);
            check_output("bp_drain_key", bus.resp_key, bp_expect[c]);
            check_output("bp_drain_hash", bus.resp_hash, hash64(bp_expect[c], BP_MASK));
            next_cycle();
            settle();
        end
        check_output("bp_busy_clear", 64'(bus.busy), 64'h0);
        check_output("bp_valid_clear", 64'(bus.resp_valid), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
